fetch_fifo_ctrl: RTL and testbench

Instruction-fetch sequencer that owns the prefetch FIFO (1-bit error + 32-bit PC + 32-bit instruction entries) between the instruction bus and decode. It issues word-aligned fetch requests only when a FIFO slot is guaranteed for the response, writes responses into the FIFO, and handles redirects (jumps) by flushing the FIFO and discarding in-flight responses. It is the only writer of the FIFO and drives its flush.

---
 rtl/fetch_fifo_ctrl_pkg.sv | 32 +++
 rtl/updown_cnt.sv | 52 +++++
 rtl/fetch_fifo_ctrl.sv | 143 ++++++++++++++
 tb/tb_fetch_fifo_ctrl.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_fifo_ctrl_pkg.sv
// Shared types and FIFO entry layout for the instruction-fetch sequencer.
// Entry layout: error bit 64, pc 63:32, instr 31:0.
package fetch_fifo_ctrl_pkg;

  localparam int ENTRY_W        = 65;
  localparam int ENTRY_ERR_BIT  = 64;
  localparam int ENTRY_PC_HI    = 63;
  localparam int ENTRY_PC_LO    = 32;
  localparam int ENTRY_INSTR_HI = 31;

  typedef enum logic [0:0] {
    S_RUN = 1'b0,
    S_ERR = 1'b1
  } fetch_state_e;

  function automatic logic [ENTRY_W-1:0] pack_entry(input logic        err,
                                                    input logic [31:0] pc,
                                                    input logic [31:0] instr);
    logic [ENTRY_W-1:0] e;
    e                             = '0;
    e[ENTRY_ERR_BIT]              = err;
    e[ENTRY_PC_HI:ENTRY_PC_LO]    = pc;
    e[ENTRY_INSTR_HI:0]           = instr;
    return e;
  endfunction

  // Fetches are always word aligned; the low address bits are discarded.
  function automatic logic [31:0] align_word(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/updown_cnt.sv
// Up/down counter with clear and load; clear beats load beats inc/dec.
// Wrapping past either end is treated as a design error.
module updown_cnt #(
  parameter int W = 2
) (
  input  logic         clk_i,
  input  logic         resetb_i,
  input  logic         en_i,
  input  logic         clear_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         inc_i,
  input  logic         dec_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_next;

  always_comb begin
    cnt_next = cnt_q;
    if (clear_i)
      cnt_next = '0;
    else if (load_i)
      cnt_next = load_val_i;
    else if (inc_i && !dec_i)
      cnt_next = cnt_q + W'(1);
    else if (dec_i && !inc_i)
      cnt_next = cnt_q - W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (!resetb_i)
      cnt_q <= '0;
    else if (en_i)
      cnt_q <= cnt_next;
  end

  assign cnt_o = cnt_q;

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (resetb_i && en_i && !clear_i && !load_i) begin
      assert (!(inc_i && !dec_i && (cnt_q == {W{1'b1}})))
        else $error("updown_cnt: increment wraps");
      assert (!(dec_i && !inc_i && (cnt_q == '0)))
        else $error("updown_cnt: decrement wraps");
    end
  end
`endif

endmodule

// File: rtl/fetch_fifo_ctrl.sv
// Instruction-fetch sequencer: credit-based requests, response writes, jump flush.
// Optional macro RV_FETCH_ERR_STALL_EN: a bus error stops fetching until a jump.
module fetch_fifo_ctrl
  import fetch_fifo_ctrl_pkg::*;
#(
  parameter int          C_FIFO_DEPTH_X = 1,
  parameter logic [31:0] C_RESET_VECTOR = 32'h0000_0000
) (
  input  logic                clk_i,
  input  logic                resetb_i,
  input  logic                clk_en_i,
  input  logic                jump_i,
  input  logic [31:0]         jump_addr_i,
  output logic                ireqvalid_o,
  output logic [31:0]         ireqaddr_o,
  input  logic                ireqready_i,
  input  logic                irspvalid_i,
  input  logic [31:0]         irspdata_i,
  input  logic                irsperror_i,
  output logic                fifo_wr_o,
  output logic [ENTRY_W-1:0]  fifo_din_o,
  output logic                fifo_flush_o,
  input  logic                fifo_rd_i
);

  localparam int            CW    = C_FIFO_DEPTH_X + 1;
  localparam logic [CW:0]   DEPTH = (CW+1)'(1) << C_FIFO_DEPTH_X;

  fetch_state_e state_q, state_next;
  logic [31:0]  pc_q, rsp_pc_q;
  logic [CW-1:0] occ_q, out_q, disc_q;
  logic [CW:0]  credit;
  logic         req_valid, accept, rsp_live, rsp_drop, rsp_wr;
  logic [CW-1:0] disc_load;

  assign credit    = DEPTH - {1'b0, occ_q} - {1'b0, out_q};
  assign req_valid = resetb_i & (state_q == S_RUN) & (credit != '0) & ~jump_i;
  assign accept    = req_valid & ireqready_i & clk_en_i;

  // A response in a jump cycle belongs to the old stream and is never written.
  assign rsp_live  = resetb_i & clk_en_i & irspvalid_i;
  assign rsp_drop  = rsp_live & (disc_q != '0);
  assign rsp_wr    = rsp_live & (disc_q == '0) & ~jump_i;
  assign disc_load = out_q - CW'(rsp_live);

  assign ireqvalid_o  = req_valid;
  assign ireqaddr_o   = pc_q;
  assign fifo_wr_o    = rsp_wr;
  assign fifo_din_o   = pack_entry(irsperror_i, rsp_pc_q, irspdata_i);
  assign fifo_flush_o = resetb_i & clk_en_i & jump_i;

  updown_cnt #(.W(CW)) u_occ (
    .clk_i      (clk_i),
    .resetb_i   (resetb_i),
    .en_i       (clk_en_i),
    .clear_i    (jump_i),
    .load_i     (1'b0),
    .load_val_i ('0),
    .inc_i      (rsp_wr),
    .dec_i      (fifo_rd_i),
    .cnt_o      (occ_q)
  );

  updown_cnt #(.W(CW)) u_out (
    .clk_i      (clk_i),
    .resetb_i   (resetb_i),
    .en_i       (clk_en_i),
    .clear_i    (1'b0),
    .load_i     (1'b0),
    .load_val_i ('0),
    .inc_i      (accept),
    .dec_i      (rsp_live),
    .cnt_o      (out_q)
  );

  updown_cnt #(.W(CW)) u_disc (
    .clk_i      (clk_i),
    .resetb_i   (resetb_i),
    .en_i       (clk_en_i),
    .clear_i    (1'b0),
    .load_i     (jump_i),
    .load_val_i (disc_load),
    .inc_i      (1'b0),
    .dec_i      (rsp_drop),
    .cnt_o      (disc_q)
  );

  always_ff @(posedge clk_i) begin
    if (!resetb_i) begin
      pc_q     <= C_RESET_VECTOR;
      rsp_pc_q <= C_RESET_VECTOR;
    end else if (clk_en_i) begin
      if (jump_i) begin
        pc_q     <= align_word(jump_addr_i);
        rsp_pc_q <= align_word(jump_addr_i);
      end else begin
        if (accept)
          pc_q <= pc_q + 32'd4;
        if (rsp_wr)
          rsp_pc_q <= rsp_pc_q + 32'd4;
      end
    end
  end

  always_comb begin
    state_next = state_q;
    if (jump_i)
      state_next = S_RUN;
`ifdef RV_FETCH_ERR_STALL_EN
    else if (rsp_wr && irsperror_i)
      state_next = S_ERR;
`endif
  end

  always_ff @(posedge clk_i) begin
    if (!resetb_i)
      state_q <= S_RUN;
    else if (clk_en_i)
      state_q <= state_next;
  end

`ifndef SYNTHESIS
  logic        hold_q;
  logic [31:0] hold_addr_q;

  always_ff @(posedge clk_i) begin
    if (!resetb_i) begin
      hold_q      <= 1'b0;
      hold_addr_q <= '0;
    end else if (clk_en_i) begin
      hold_q      <= req_valid & ~ireqready_i;
      hold_addr_q <= pc_q;
      assert (!(irspvalid_i && (out_q == '0)))
        else $error("fetch_fifo_ctrl: response with nothing outstanding");
      assert (!(fifo_rd_i && (occ_q == '0)))
        else $error("fetch_fifo_ctrl: pop from empty fifo");
      assert (!(hold_q && (pc_q != hold_addr_q)))
        else $error("fetch_fifo_ctrl: request address changed while stalled");
    end
  end
`endif

endmodule

// File: tb/tb_fetch_fifo_ctrl.sv
// Directed bench for fetch_fifo_ctrl with a queue-based reference model.
module tb_fetch_fifo_ctrl;

  localparam int          X  = 1;
  localparam int          D  = 2;
  localparam logic [31:0] RV = 32'h0000_0000;
`ifdef RV_FETCH_ERR_STALL_EN
  localparam bit ERR_STALL = 1'b1;
`else
  localparam bit ERR_STALL = 1'b0;
`endif

  logic        clk;
  logic        resetb, clk_en, jump, ireqready, irspvalid, irsperror, fifo_rd;
  logic [31:0] jaddr, irspdata, ireqaddr;
  logic        ireqvalid, fifo_wr, fifo_flush;
  logic [64:0] fifo_din;

  fetch_fifo_ctrl #(.C_FIFO_DEPTH_X(X), .C_RESET_VECTOR(RV)) dut (
    .clk_i        (clk),
    .resetb_i     (resetb),
    .clk_en_i     (clk_en),
    .jump_i       (jump),
    .jump_addr_i  (jaddr),
    .ireqvalid_o  (ireqvalid),
    .ireqaddr_o   (ireqaddr),
    .ireqready_i  (ireqready),
    .irspvalid_i  (irspvalid),
    .irspdata_i   (irspdata),
    .irsperror_i  (irsperror),
    .fifo_wr_o    (fifo_wr),
    .fifo_din_o   (fifo_din),
    .fifo_flush_o (fifo_flush),
    .fifo_rd_i    (fifo_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: every accepted request is remembered with its address;
  // a jump marks everything still in flight as stale.
  typedef struct {
    logic [31:0] addr;
    bit          drop;
  } pend_t;

  pend_t       pend[$];
  logic [31:0] m_pc  = RV;
  int          m_occ = 0;
  bit          m_err = 1'b0;

  // Bus/consumer stimulus state, driven from observed DUT handshakes.
  logic [31:0] resp_q[$];
  int          c_cnt    = 0;
  logic [31:0] err_addr = 32'h0000_0001;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  always @(negedge clk) begin
    logic        exp_valid, exp_wr, exp_flush, acc;
    logic [64:0] exp_din;
    int          credit;
    pend_t       head;

    credit    = D - m_occ - pend.size();
    exp_valid = resetb && !m_err && (credit != 0) && !jump;
    exp_flush = resetb && jump && clk_en;
    exp_wr    = resetb && clk_en && irspvalid && !jump && (pend.size() > 0) && !pend[0].drop;
    exp_din   = '0;
    if (exp_wr)
      exp_din = {irsperror, pend[0].addr, irspdata};

    chk("ireqvalid", {64'd0, ireqvalid}, {64'd0, exp_valid});
    chk("fifo_flush", {64'd0, fifo_flush}, {64'd0, exp_flush});
    chk("fifo_wr", {64'd0, fifo_wr}, {64'd0, exp_wr});
    if (exp_valid)
      chk("ireqaddr", {33'd0, ireqaddr}, {33'd0, m_pc});
    if (exp_wr)
      chk("fifo_din", fifo_din, exp_din);

    if (!resetb) begin
      pend.delete();
      m_pc  = RV;
      m_occ = 0;
      m_err = 1'b0;
    end else if (clk_en) begin
      acc = exp_valid && ireqready;
      if (irspvalid && pend.size() > 0) begin
        head = pend.pop_front();
        if (exp_wr) begin
          m_occ++;
          if (irsperror && ERR_STALL)
            m_err = 1'b1;
        end
      end
      if (fifo_rd)
        m_occ--;
      if (jump) begin
        foreach (pend[i]) pend[i].drop = 1'b1;
        m_occ = 0;
        m_err = 1'b0;
        m_pc  = {jaddr[31:2], 2'b00};
      end else if (acc) begin
        pend.push_back('{addr: m_pc, drop: 1'b0});
        m_pc = m_pc + 32'd4;
      end
    end

    if (!resetb) begin
      resp_q.delete();
      c_cnt = 0;
    end else if (clk_en) begin
      if (irspvalid && resp_q.size() > 0)
        void'(resp_q.pop_front());
      if (ireqvalid && ireqready)
        resp_q.push_back(ireqaddr);
      if (fifo_flush)
        c_cnt = 0;
      else
        c_cnt = c_cnt + int'(fifo_wr) - int'(fifo_rd);
    end
  end

  bit          s_rst = 1'b0, s_en = 1'b1, s_rdy = 1'b0, s_jump = 1'b0;
  bit          s_hold = 1'b0, s_pop = 1'b0;
  logic [31:0] s_jaddr = '0;

  task automatic tick();
    @(posedge clk);
    #1;
    resetb    = s_rst;
    clk_en    = s_en;
    ireqready = s_rdy;
    jump      = s_jump;
    jaddr     = s_jaddr;
    fifo_rd   = s_rst && s_pop && (c_cnt > 0);
    if (s_rst && !s_hold && resp_q.size() > 0) begin
      irspvalid = 1'b1;
      irspdata  = instr_of(resp_q[0]);
      irsperror = (resp_q[0] == err_addr);
    end else begin
      irspvalid = 1'b0;
      irspdata  = '0;
      irsperror = 1'b0;
    end
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    s_rst = 1'b0; s_jump = 1'b0; s_rdy = 1'b0; s_hold = 1'b0; s_pop = 1'b0; s_en = 1'b1;
    run(2);
    s_rst = 1'b1;
  endtask

  // Ticks until a FIFO write with the given pc appears; a timeout is a failure.
  task automatic wait_wr(input string name, input logic [31:0] pc, output bit found, input bit quiet);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      #1;
      if (fifo_wr && fifo_din[63:32] == pc)
        found = 1'b1;
    end
    if (!quiet) begin
      checks++;
      if (!found) begin
        errors++;
        $display("FAIL %s: no fifo write with pc %h within 20 cycles", name, pc);
      end
    end
  endtask

  bit found;

  initial begin
    resetb = 1'b0; clk_en = 1'b1; jump = 1'b0; jaddr = '0; ireqready = 1'b0;
    irspvalid = 1'b0; irspdata = '0; irsperror = 1'b0; fifo_rd = 1'b0;

    // Sequential fetch into a FIFO with no consumer
    run(2);
    #1 chk("reset_valid", {64'd0, ireqvalid}, 65'd0);
    s_rst = 1'b1; s_rdy = 1'b1;
    tick(); #1;
    chk("first_valid", {64'd0, ireqvalid}, 65'd1);
    chk("first_addr", {33'd0, ireqaddr}, 65'h0);
    tick(); #1;
    chk("second_addr", {33'd0, ireqaddr}, 65'h4);
    chk("wr_pc0", {33'd0, fifo_din[63:32]}, 65'h0);
    tick(); #1;
    chk("wr_pc4", {33'd0, fifo_din[63:32]}, 65'h4);
    chk("no_credit", {64'd0, ireqvalid}, 65'd0);
    run(2); #1;
    chk("full_stall", {64'd0, ireqvalid}, 65'd0);
    s_pop = 1'b1;
    tick(); #1;
    chk("pop_same_cycle", {64'd0, ireqvalid}, 65'd0);
    s_pop = 1'b0;
    tick(); #1;
    chk("pop_reenable", {64'd0, ireqvalid}, 65'd1);
    chk("pop_reenable_addr", {33'd0, ireqaddr}, 65'h8);
    s_en = 1'b0; s_pop = 1'b1;
    run(2);
    s_en = 1'b1;
    run(4);

    // Jump with two requests in flight
    do_reset();
    s_hold = 1'b1; s_rdy = 1'b1; s_pop = 1'b1;
    run(2);
    s_jump = 1'b1; s_jaddr = 32'h0000_0103;
    tick(); #1;
    chk("jump_flush", {64'd0, fifo_flush}, 65'd1);
    chk("jump_no_req", {64'd0, ireqvalid}, 65'd0);
    s_jump = 1'b0; s_hold = 1'b0;
    wait_wr("jump_target_entry", 32'h0000_0100, found, 1'b0);
    run(3);

    // Jump coinciding with the only outstanding response
    do_reset();
    s_hold = 1'b1; s_rdy = 1'b1;
    tick();
    s_rdy = 1'b0; s_hold = 1'b0; s_jump = 1'b1; s_jaddr = 32'h0000_0200;
    tick(); #1;
    chk("jump_rsp_nowr", {64'd0, fifo_wr}, 65'd0);
    chk("jump_rsp_flush", {64'd0, fifo_flush}, 65'd1);
    s_jump = 1'b0; s_rdy = 1'b1;
    wait_wr("jump_rsp_target", 32'h0000_0200, found, 1'b0);
    chk("jump_rsp_data", {33'd0, fifo_din[31:0]}, {33'd0, instr_of(32'h0000_0200)});

    // Bus error on the second fetch
    do_reset();
    err_addr = 32'h0000_0004;
    s_rdy = 1'b1; s_pop = 1'b1;
    wait_wr("err_entry", 32'h0000_0004, found, 1'b0);
    chk("err_bit", {64'd0, fifo_din[64]}, 65'd1);
`ifdef RV_FETCH_ERR_STALL_EN
    run(4); #1;
    chk("err_stall", {64'd0, ireqvalid}, 65'd0);
`else
    wait_wr("err_continue", 32'h0000_0008, found, 1'b0);
`endif
    s_jump = 1'b1; s_jaddr = 32'h0000_0040;
    tick();
    s_jump = 1'b0;
    tick(); #1;
    chk("err_recover_valid", {64'd0, ireqvalid}, 65'd1);
    chk("err_recover_addr", {33'd0, ireqaddr}, 65'h40);
    err_addr = 32'h0000_0001;
    run(4);

    // Address wrap, then a reset with traffic in flight
    do_reset();
    s_jump = 1'b1; s_jaddr = 32'hFFFF_FFFC;
    tick();
    s_jump = 1'b0; s_rdy = 1'b1; s_pop = 1'b1;
    tick(); #1;
    chk("wrap_addr_hi", {33'd0, ireqaddr}, 65'hFFFF_FFFC);
    tick(); #1;
    chk("wrap_addr_zero", {33'd0, ireqaddr}, 65'h0);
    chk("wrap_valid", {64'd0, ireqvalid}, 65'd1);
    tick();
    s_rst = 1'b0; s_jump = 1'b1;
    tick(); #1;
    chk("midrst_valid", {64'd0, ireqvalid}, 65'd0);
    chk("midrst_flush", {64'd0, fifo_flush}, 65'd0);
    chk("midrst_wr", {64'd0, fifo_wr}, 65'd0);
    s_jump = 1'b0; s_rst = 1'b1;
    tick(); #1;
    chk("post_rst_valid", {64'd0, ireqvalid}, 65'd1);
    chk("post_rst_addr", {33'd0, ireqaddr}, {33'd0, RV});
    run(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
